uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one SN75155 UART transmitter among NUM_REQ byte sources. Each requester presents a byte with a level request. The arbiter grants one requester at a time, round-robin, and latches its byte. It then drives the transmitter's transmit/data inputs and holds off further grants until the frame time has elapsed. It sits between the byte producers and the SN75155 instance, and owns all sequencing of that transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 10416, clocks per transmitter baud tick; must equal the transmitter's counter period
FRAME_TICKS, 12, baud ticks reserved per frame after start: 1 load + 10 shift + 1 clear
IDW, 2, grant index width, equal to clog2(NUM_REQ)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until ack
req_data  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i]
ack  out  NUM_REQ  one-cycle pulse to the granted requester when its byte is latched
busy  out  1  high in any state other than IDLE
grant_id  out  IDW  index of the current or last grantee
tx_transmit  out  1  drives the transmitter's transmit input
tx_data  out  8  drives the transmitter's data input; holds the latched byte

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, busy=0, grant_id=0, tx_transmit=0, tx_data=0, rr_ptr=0, cycle counter=0.
- States: IDLE, START, WAIT.
- IDLE:
  - If any req bit is 1 on a clk edge, select the winner. Round-robin picks the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On that edge: latch tx_data from the winner's req_data, set grant_id, pulse ack[winner] for exactly one cycle, set rr_ptr=(winner+1) mod NUM_REQ, clear the counter, go to START.
  - Latency: req sampled at edge N gives ack and tx_transmit high after edge N.
- START:
  - tx_transmit=1 for exactly CLKS_PER_BIT cycles, so one transmitter baud tick is guaranteed to sample it. Then go to WAIT with the counter cleared.
- WAIT:
  - tx_transmit=0 for FRAME_TICKS*CLKS_PER_BIT cycles, then go to IDLE.
  - The next grant can occur on the first IDLE edge; there is no extra idle cycle.
- tx_data holds its value from grant until the next grant and never changes mid-frame.
- req bits are ignored outside IDLE. A request deasserted before grant is never acked. A request deasserted after ack has no effect on the frame.
- Simultaneous requests: exactly one ack per frame. A continuously asserted requester is re-granted only after every other pending requester has been served.
- Counter: width clog2(FRAME_TICKS*CLKS_PER_BIT)+1, unsigned. It saturates only by state exit, never by wrap.
- Reset mid-frame: tx_transmit drops at once and any partially scheduled frame is abandoned. The transmitter has its own reset, which the system ties to the same source.
- req_data for non-granted requesters is don't-care.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- Every other behaviour is identical in both builds.

Decomposition:
- Package uart_arb_pkg holds: the state enum (IDLE, START, WAIT), default CLKS_PER_BIT and FRAME_TICKS, and the frame-length constant function.
- One sub-module, uart_arb_pick: combinational priority picker taking req and rr_ptr, returning a valid flag and the winner index. The macro selects its fixed-priority variant.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FRAME_TICKS=12.
1. Single request: req=4'b0001, req_data[7:0]=8'hA5 -> ack[0] high for 1 cycle next edge; tx_data=8'hA5; tx_transmit high for 4 cycles; busy high for 52 cycles; IDLE after.
2. All four requesters held high with bytes 8'h10/8'h11/8'h12/8'h13 -> grants in order 0,1,2,3, one per 52-cycle frame; each ack pulses once; tx_data sequence 10,11,12,13.
3. Fairness: req0 held permanently, req2 asserted mid-frame of req0 -> next grant goes to 2, then back to 0.
4. Request withdrawn: req1 pulsed for 2 cycles during WAIT, then low -> no ack[1]; arbiter returns to IDLE, grant_id unchanged.
5. Reset mid-frame: assert reset=0 during START cycle 2 -> tx_transmit=0, busy=0, ack=0 immediately (asynchronous); after release, req=4'b1000 is granted first since rr_ptr=0 and no lower request is pending.
6. With UART_ARB_FIXED_PRIO_EN defined: req=4'b1010 held -> requester 1 granted every frame and requester 3 never acked.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } arb_state_e;

    // Defaults match the SN75155 counter period and a 1+10+1 tick frame
    localparam int unsigned DefClksPerBit = 10416;
    localparam int unsigned DefFrameTicks = 12;

    // Clock cycles the arbiter holds off after the start pulse
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned frame_ticks);
        return clks_per_bit * frame_ticks;
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational requester picker.
// Default: round-robin search from rr_ptr upward, wrapping.
// With UART_ARB_FIXED_PRIO_EN defined: lowest set index wins, rr_ptr unused.
module uart_arb_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               valid,
    output logic [IDW-1:0]     winner
);

`ifdef UART_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^rr_ptr;

    // Descending scan so the lowest set index is the last to overwrite
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid  = 1'b1;
                winner = IDW'(k);
            end
        end
    end
`else
    int unsigned      idx;
    logic [IDW-1:0]   sel;

    // First set bit at or above rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDW'(idx);
            if (!valid && req[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one SN75155 UART transmitter among NUM_REQ byte sources.
// Grants one requester per frame, latches its byte, pulses transmit for one
// baud tick, then holds off grants for the rest of the frame.
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned FRAME_TICKS  = DefFrameTicks,
    parameter int unsigned IDW          = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data
);

    localparam int unsigned     WaitCycles = frame_cycles(CLKS_PER_BIT, FRAME_TICKS);
    localparam int unsigned     CntW       = $clog2(WaitCycles) + 1;
    localparam logic [CntW-1:0] StartLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] WaitLast   = CntW'(WaitCycles - 1);

    arb_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          data_q, data_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [IDW-1:0]      rr_ptr;
    logic                pick_valid;
    logic [IDW-1:0]      pick_winner;
    logic                grant_now;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDW-1:0] rr_q, rr_d;

    // Pointer moves just past the winner on every grant
    always_comb begin
        rr_d = rr_q;
        if (grant_now) begin
            rr_d = (pick_winner == IDW'(NUM_REQ - 1)) ? '0 : pick_winner + IDW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_ptr = rr_q;
`endif

    uart_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Requests only count while idle
    assign grant_now = (state_q == StIdle) && pick_valid;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start pulse for one baud period, then frame hold-off
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_now) state_d = StStart;
            StStart: if (cnt_q == StartLast) state_d = StWait;
            StWait:  if (cnt_q == WaitLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: counter, latched byte, grant index, ack pulse
    always_comb begin
        cnt_d   = cnt_q + CntW'(1);
        data_d  = data_q;
        grant_d = grant_q;
        ack_d   = '0;
        case (state_q)
            StIdle:  cnt_d = '0;
            StStart: if (cnt_q == StartLast) cnt_d = '0;
            StWait:  if (cnt_q == WaitLast) cnt_d = '0;
            default: cnt_d = '0;
        endcase
        if (grant_now) begin
            data_d             = req_data[{pick_winner, 3'b000} +: 8];
            grant_d            = pick_winner;
            ack_d[pick_winner] = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
        end
    end

    // Outputs decoded from state so reset drops tx_transmit immediately
    always_comb begin
        busy        = (state_q != StIdle);
        tx_transmit = (state_q == StStart);
        ack         = ack_q;
        grant_id    = grant_q;
        tx_data     = data_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, FRAME_TICKS=12
// (52-cycle busy window per frame).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_transmit;
    logic [7:0]  tx_data;

    int checks   = 0;
    int failures = 0;
    int ack_cnt [4];

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (4),
        .FRAME_TICKS  (12),
        .IDW          (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .tx_transmit (tx_transmit),
        .tx_data     (tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tx_transmit", 32'(tx_transmit), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        reset = 1'b1;
    endtask

    // Waits for an ack pulse; reports winner index and cycles waited
    task automatic wait_grant(output int idx, output int waited);
        logic found;
        found  = 1'b0;
        idx    = -1;
        waited = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            waited++;
            if (ack != 4'b0000) begin
                found = 1'b1;
                for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
                break;
            end
        end
        check("grant_found", 32'(found), 1);
        if (found) begin
            check("ack_onehot", 32'($countones(ack)), 1);
            check("grant_tx_transmit", 32'(tx_transmit), 1);
        end
    endtask

    // Counts busy and transmit cycles from the current sample until idle
    task automatic wait_idle(input logic [7:0] exp_data, output int busy_cyc,
                             output int tx_cyc);
        int data_bad;
        busy_cyc = 0;
        tx_cyc   = 0;
        data_bad = 0;
        for (int n = 0; n < 300; n++) begin
            if (!busy) break;
            busy_cyc++;
            if (tx_transmit) tx_cyc++;
            if (tx_data !== exp_data) data_bad++;
            @(negedge clk);
        end
        check("idle_reached", 32'(busy), 0);
        check("tx_data_stable", 32'(data_bad), 0);
    endtask

    int idx, waited, bcyc, tcyc, a_before;

    initial begin
        req      = '0;
        req_data = '0;
        reset    = 1'b1;
        #2;
        do_reset();

        // 1. Single request
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        wait_grant(idx, waited);
        check("t1_idx", 32'(idx), 0);
        check("t1_latency", 32'(waited), 1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        check("t1_grant_id", 32'(grant_id), 0);
        req      = 4'b0000;
        req_data = 32'hFFFF_FFFF;
        wait_idle(8'hA5, bcyc, tcyc);
        check("t1_busy_cycles", 32'(bcyc), 52);
        check("t1_tx_cycles", 32'(tcyc), 4);
        repeat (2) @(negedge clk);
        check("t1_ack0_count", 32'(ack_cnt[0]), 1);
        check("t1_tx_data_hold", 32'(tx_data), 32'hA5);

`ifndef UART_ARB_FIXED_PRIO_EN
        // 2. Four simultaneous requesters, round-robin from rr_ptr=0
        do_reset();
        req_data = 32'h1312_1110;
        req      = 4'b1111;
        for (int f = 0; f < 4; f++) begin
            a_before = ack_cnt[f];
            wait_grant(idx, waited);
            check("t2_idx", 32'(idx), 32'(f));
            check("t2_latency", 32'(waited), 1);
            check("t2_tx_data", 32'(tx_data), 32'h10 + 32'(f));
            req[f] = 1'b0;
            wait_idle(8'h10 + 8'(f), bcyc, tcyc);
            check("t2_busy_cycles", 32'(bcyc), 52);
            check("t2_ack_once", 32'(ack_cnt[f] - a_before), 1);
        end

        // 3. Fairness: req0 held, req2 joins mid-frame
        req_data = 32'hC2B2_A291;
        req      = 4'b0001;
        wait_grant(idx, waited);
        check("t3_first", 32'(idx), 0);
        repeat (10) @(negedge clk);
        req[2] = 1'b1;
        wait_idle(8'h91, bcyc, tcyc);
        wait_grant(idx, waited);
        check("t3_second", 32'(idx), 2);
        check("t3_second_data", 32'(tx_data), 32'hB2);
        req[2] = 1'b0;
        wait_idle(8'hB2, bcyc, tcyc);
        wait_grant(idx, waited);
        check("t3_third", 32'(idx), 0);
        req = 4'b0000;

        // 4. req1 pulsed for two cycles during WAIT is never acked
        a_before = ack_cnt[1];
        repeat (10) @(negedge clk);
        req = 4'b0010;
        repeat (2) @(negedge clk);
        req = 4'b0000;
        wait_idle(8'h91, bcyc, tcyc);
        repeat (3) @(negedge clk);
        check("t4_no_ack1", 32'(ack_cnt[1] - a_before), 0);
        check("t4_grant_id", 32'(grant_id), 0);
        check("t4_idle", 32'(busy), 0);

        // 5. Asynchronous reset during START cycle 2
        req = 4'b0100;
        wait_grant(idx, waited);
        check("t5_pre_idx", 32'(idx), 2);
        req = 4'b0000;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("t5_tx_transmit", 32'(tx_transmit), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ack", 32'(ack), 0);
        check("t5_grant_id", 32'(grant_id), 0);
        req = 4'b1000;
        @(negedge clk);
        reset = 1'b1;
        wait_grant(idx, waited);
        check("t5_post_idx", 32'(idx), 3);
        check("t5_post_latency", 32'(waited), 1);
        check("t5_post_data", 32'(tx_data), 32'hC2);
        req = 4'b0000;
        wait_idle(8'hC2, bcyc, tcyc);
        check("t5_busy_cycles", 32'(bcyc), 52);
`else
        // 6. Fixed priority: requester 1 always beats requester 3
        do_reset();
        req_data = 32'h3300_1100;
        req      = 4'b1010;
        a_before = ack_cnt[3];
        for (int f = 0; f < 3; f++) begin
            wait_grant(idx, waited);
            check("t6_idx", 32'(idx), 1);
            check("t6_tx_data", 32'(tx_data), 32'h11);
            wait_idle(8'h11, bcyc, tcyc);
            check("t6_busy_cycles", 32'(bcyc), 52);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("t6_no_ack3", 32'(ack_cnt[3] - a_before), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
